// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and the detectors it feeds.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_e;

  localparam int         PAT_W_DFLT  = 5;
  localparam logic [4:0] DEFAULT_PAT = 5'b01010;

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in serial-out shift register: loads a word, shifts left, MSB is the serial output.
module piso_shreg #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         msb_o
);

  logic [W-1:0] q_q, q_d;

  // Load wins over shift; shifting in zeros leaves the register empty after W shifts.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = data_i;
    end else if (shift_i) begin
      q_d = {q_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign msb_o = q_q[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, rep+1 times with gap idle cycles between sends.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int               PAT_W       = 5,
  parameter int               REP_W       = 4,
  parameter int               GAP_W       = 4,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = seq_pkg::DEFAULT_PAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             use_dflt,
  input  logic [PAT_W-1:0] pattern,
  input  logic [REP_W-1:0] rep,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only in IDLE (and ignored when abort is also high);
  // busy stays high from the cycle after acceptance until IDLE is re-entered, and
  // done pulses for exactly one cycle after the last bit of the last send.

  localparam int               CNT_W   = $clog2(PAT_W);
  localparam logic [CNT_W-1:0] BIT_MAX = CNT_W'(PAT_W - 1);

  tx_state_e        state_q, state_d;
  logic             xv_q, xv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [PAT_W-1:0] pat_q, pat_d;

  logic             sh_load, sh_shift;
  logic [PAT_W-1:0] sh_data;
  logic             sh_msb;

  piso_shreg #(.W(PAT_W)) u_shreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .data_i  (sh_data),
    .msb_o   (sh_msb)
  );

  always_comb begin
    state_d  = state_q;
    xv_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    bit_d    = bit_q;
    rep_d    = rep_q;
    gcnt_d   = gcnt_q;
    gap_d    = gap_q;
    pat_d    = pat_q;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_data  = pat_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          pat_d   = use_dflt ? DEFAULT_PAT : pattern;
          rep_d   = rep;
          gap_d   = gap;
          sh_load = 1'b1;
          sh_data = pat_d;
          xv_d    = 1'b1;
          busy_d  = 1'b1;
          bit_d   = BIT_MAX;
          state_d = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          sh_load = 1'b1;
          sh_data = '0;
          state_d = IDLE;
        end else if (bit_q != '0) begin
          sh_shift = 1'b1;
          xv_d     = 1'b1;
          busy_d   = 1'b1;
          bit_d    = bit_q - CNT_W'(1);
        end else if (rep_q != '0) begin
          rep_d  = rep_q - REP_W'(1);
          busy_d = 1'b1;
          if (gap_q != '0) begin
            // Shifting past the last bit empties the register, so x idles at 0 in GAP.
            sh_shift = 1'b1;
            gcnt_d   = gap_q;
            state_d  = GAP;
          end else begin
            sh_load = 1'b1;
            xv_d    = 1'b1;
            bit_d   = BIT_MAX;
          end
        end else begin
          sh_shift = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      GAP: begin
        if (abort) begin
          sh_load = 1'b1;
          sh_data = '0;
          state_d = IDLE;
        end else begin
          busy_d = 1'b1;
          if (gcnt_q == GAP_W'(1)) begin
            sh_load = 1'b1;
            xv_d    = 1'b1;
            bit_d   = BIT_MAX;
            state_d = SEND;
          end else begin
            gcnt_d = gcnt_q - GAP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bit_q   <= '0;
      rep_q   <= '0;
      gcnt_q  <= '0;
      gap_q   <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      xv_q    <= xv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bit_q   <= bit_d;
      rep_q   <= rep_d;
      gcnt_q  <= gcnt_d;
      gap_q   <= gap_d;
      pat_q   <= pat_d;
    end
  end

  assign x         = sh_msb;
  assign x_valid   = xv_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed table-driven bench for seq_pattern_tx with a small 01010 detector model on x.
module tb_seq_pattern_tx;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       use_dflt = 1'b0;
  logic [4:0] pattern = '0;
  logic [3:0] rep = '0;
  logic [3:0] gap = '0;
  logic       abort = 1'b0;
  logic       x, x_valid, busy, done;
  logic [1:0] dbg_state;

  typedef struct {
    logic       start;
    logic       use_dflt;
    logic [4:0] pattern;
    logic [3:0] rep;
    logic [3:0] gap;
    logic       abort;
    logic [3:0] exp;  // {x, x_valid, busy, done} after the edge
  } vec_t;

  vec_t       vecs[$];
  int         n_tests = 0;
  int         n_fail = 0;
  logic [4:0] hist = '0;
  int         det_cnt = 0;

  seq_pattern_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .use_dflt  (use_dflt),
    .pattern   (pattern),
    .rep       (rep),
    .gap       (gap),
    .abort     (abort),
    .x         (x),
    .x_valid   (x_valid),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic s, input logic d, input logic [4:0] p,
                              input logic [3:0] r, input logic [3:0] g,
                              input logic a, input logic [3:0] e);
    vec_t v;
    v.start = s; v.use_dflt = d; v.pattern = p; v.rep = r; v.gap = g; v.abort = a; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string name, input int idx);
    @(negedge clk);
    start = v.start; use_dflt = v.use_dflt; pattern = v.pattern;
    rep = v.rep; gap = v.gap; abort = v.abort;
    @(posedge clk);
    #1;
    hist = {hist[3:0], x};
    if (hist == 5'b01010) det_cnt++;
    n_tests++;
    if ({x, x_valid, busy, done} !== v.exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got x/xv/busy/done=%b expected %b", name, idx,
               {x, x_valid, busy, done}, v.exp);
    end
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], name, i);
    vecs.delete();
  endtask

  // Row 0 starts the send; later rows drive junk pattern/rep/gap to prove the latched copies are used.
  task automatic queue_send(input logic d, input logic [4:0] p, input logic [3:0] r,
                            input logic [3:0] g, input logic hold,
                            input logic [31:0] ex, input logic [31:0] ev, input int len);
    vecs.push_back(mk(1'b1, d, p, r, g, 1'b0, {ex[len-1], ev[len-1], 2'b10}));
    for (int i = 1; i < len; i++)
      vecs.push_back(mk(hold, ~d, ~p, 4'd0, 4'd0, 1'b0, {ex[len-1-i], ev[len-1-i], 2'b10}));
  endtask

  initial begin
    int   xv_cnt, busy_cnt;
    logic seen;

    // Reset held for two cycles, then idle with start low.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {x, x_valid, busy, done}, 4'b0000);
    check("reset_state", dbg_state, IDLE);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, 1'b0, 5'h1f, 4'd0, 4'd0, 1'b0, 4'b0000));
    run_table("idle_after_reset");

    // Single default send, pattern input deliberately different.
    hist = '0; det_cnt = 0;
    vecs.push_back(mk(1'b1, 1'b1, 5'b11111, 4'd0, 4'd0, 1'b0, 4'b0110));
    vecs.push_back(mk(1'b0, 1'b0, 5'b11111, 4'd0, 4'd0, 1'b0, 4'b1110));
    vecs.push_back(mk(1'b0, 1'b0, 5'b11111, 4'd0, 4'd0, 1'b0, 4'b0110));
    vecs.push_back(mk(1'b0, 1'b0, 5'b11111, 4'd0, 4'd0, 1'b0, 4'b1110));
    vecs.push_back(mk(1'b0, 1'b0, 5'b11111, 4'd0, 4'd0, 1'b0, 4'b0110));
    vecs.push_back(mk(1'b0, 1'b0, 5'b11111, 4'd0, 4'd0, 1'b0, 4'b0001));
    vecs.push_back(mk(1'b0, 1'b0, 5'b11111, 4'd0, 4'd0, 1'b0, 4'b0000));
    vecs.push_back(mk(1'b0, 1'b0, 5'b11111, 4'd0, 4'd0, 1'b0, 4'b0000));
    run_table("single_send");
    check("single_send_detects", det_cnt, 1);

    // Repeat with gap, start held high while busy (must be ignored).
    queue_send(1'b0, 5'b11001, 4'd2, 4'd3, 1'b1,
               32'b110010001100100011001, 32'b111110001111100011111, 21);
    vecs.push_back(mk(1'b1, 1'b0, 5'b00000, 4'd0, 4'd0, 1'b0, 4'b0001));
    vecs.push_back(mk(1'b0, 1'b0, 5'b00000, 4'd0, 4'd0, 1'b0, 4'b0000));
    vecs.push_back(mk(1'b0, 1'b0, 5'b00000, 4'd0, 4'd0, 1'b0, 4'b0000));
    run_table("repeat_gap");

    // Back-to-back repeats, then a new start accepted in the done cycle.
    hist = '0; det_cnt = 0;
    queue_send(1'b1, 5'b00000, 4'd1, 4'd0, 1'b0, 32'b0101001010, 32'b1111111111, 10);
    vecs.push_back(mk(1'b0, 1'b0, 5'b00000, 4'd0, 4'd0, 1'b0, 4'b0001));
    run_table("back_to_back");
    check("back_to_back_detects", det_cnt, 2);
    queue_send(1'b0, 5'b10011, 4'd0, 4'd0, 1'b0, 32'b10011, 32'b11111, 5);
    vecs.push_back(mk(1'b0, 1'b0, 5'b00000, 4'd0, 4'd0, 1'b0, 4'b0001));
    vecs.push_back(mk(1'b0, 1'b0, 5'b00000, 4'd0, 4'd0, 1'b0, 4'b0000));
    run_table("start_on_done");

    // Abort on the third bit, then abort/start interplay in IDLE, then a clean send.
    queue_send(1'b1, 5'b00000, 4'd0, 4'd0, 1'b0, 32'b010, 32'b111, 3);
    vecs.push_back(mk(1'b0, 1'b0, 5'b00000, 4'd0, 4'd0, 1'b1, 4'b0000));
    vecs.push_back(mk(1'b0, 1'b0, 5'b00000, 4'd0, 4'd0, 1'b0, 4'b0000));
    vecs.push_back(mk(1'b1, 1'b1, 5'b00000, 4'd0, 4'd0, 1'b1, 4'b0000));
    vecs.push_back(mk(1'b0, 1'b0, 5'b00000, 4'd0, 4'd0, 1'b1, 4'b0000));
    queue_send(1'b1, 5'b00000, 4'd0, 4'd0, 1'b0, 32'b01010, 32'b11111, 5);
    vecs.push_back(mk(1'b0, 1'b0, 5'b00000, 4'd0, 4'd0, 1'b0, 4'b0001));
    vecs.push_back(mk(1'b0, 1'b0, 5'b00000, 4'd0, 4'd0, 1'b0, 4'b0000));
    run_table("abort_send");

    // Abort during a gap.
    queue_send(1'b0, 5'b11001, 4'd1, 4'd3, 1'b0, 32'b110010, 32'b111110, 6);
    vecs.push_back(mk(1'b0, 1'b0, 5'b00000, 4'd0, 4'd0, 1'b1, 4'b0000));
    vecs.push_back(mk(1'b0, 1'b0, 5'b00000, 4'd0, 4'd0, 1'b0, 4'b0000));
    run_table("abort_gap");

    // Async reset mid-gap with start held high while busy.
    queue_send(1'b0, 5'b11001, 4'd1, 4'd4, 1'b1, 32'b1100100, 32'b1111100, 7);
    run_table("pre_reset");
    #1 rst_n = 1'b0;
    start = 1'b0;
    #1;
    check("async_reset_outputs", {x, x_valid, busy, done}, 4'b0000);
    check("async_reset_state", dbg_state, IDLE);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) vecs.push_back(mk(1'b0, 1'b0, 5'b11001, 4'd1, 4'd4, 1'b0, 4'b0000));
    run_table("after_reset_no_send");

    // Maximum repeat count: 16 sends back to back, no wrap.
    @(negedge clk);
    start = 1'b1; use_dflt = 1'b1; rep = 4'd15; gap = 4'd0; abort = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    xv_cnt = 0; busy_cnt = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      if (done) seen = 1'b1;
      else begin
        if (x_valid) xv_cnt++;
        if (busy) busy_cnt++;
        @(posedge clk);
        #1;
      end
    end
    check("rep_max_done_seen", seen, 1'b1);
    check("rep_max_valid_cycles", xv_cnt, 80);
    check("rep_max_busy_cycles", busy_cnt, 80);
    @(posedge clk);
    #1;
    check("rep_max_idle_after", {x, x_valid, busy, done}, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
